opfwd_issue_stage: RTL

Registered ID→EX operand stage with a parametrised in-flight destination scoreboard, priority-ordered forwarding from `FWD_DEPTH` downstream stages, load-use interlock, freeze and flush. It is the next generation of the combinational ALU operand/forwarding mux. It derives its own forwarding selects from tracked destination tags instead of taking externally supplied select codes. It also owns the EX pipeline register.

---
 rtl/opfwd_pkg.sv | 29 ++
 rtl/opfwd_issue_stage_if.sv | 54 +++++
 rtl/opfwd_src_sel.sv | 46 ++++
 rtl/opfwd_issue_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/opfwd_pkg.sv
// Shared types and constants for the operand-forwarding issue stage.
//   sb_entry_t     : one in-flight destination record {valid, rd, we, is_load}
//   opfwd_rd_t     : register tag, wide enough for any REG_AW up to OPFWD_RD_W
//   OPFWD_ZERO_REG : hard-wired zero register tag
package opfwd_pkg;

    // Tags are stored at a fixed width so the struct does not depend on a module
    // parameter; narrower REG_AW values are zero-extended into it.
    localparam int unsigned OPFWD_RD_W = 8;

    typedef logic [OPFWD_RD_W-1:0] opfwd_rd_t;

    localparam opfwd_rd_t OPFWD_ZERO_REG = '0;

    typedef struct packed {
        logic      valid;
        opfwd_rd_t rd;
        logic      we;
        logic      is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_EMPTY = '0;

    // True when an in-flight entry will produce the value of register addr.
    function automatic logic sb_match(input sb_entry_t e, input opfwd_rd_t addr);
        return e.valid & e.we & (e.rd == addr) & (addr != OPFWD_ZERO_REG);
    endfunction

endpackage

// File: rtl/opfwd_issue_stage_if.sv
// Bundle of the ID-side request, downstream forwarding bus, pipeline controls and the
// EX-register outputs of opfwd_issue_stage.
//   master : decode/pipeline side (drives id_*, fwd_data, pipe_stall, flush)
//   slave  : the issue stage (drives id_ready, ex_*, perf_*)
interface opfwd_issue_stage_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FWD_DEPTH = 3
);

    logic                      id_valid;
    logic                      id_ready;
    logic [REG_AW-1:0]         id_rs1_addr;
    logic [REG_AW-1:0]         id_rs2_addr;
    logic [XLEN-1:0]           id_rs1_data;
    logic [XLEN-1:0]           id_rs2_data;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_rd_we;
    logic                      id_is_load;
    logic                      id_use_imm;
    logic [XLEN-1:0]           id_imm;

    logic [FWD_DEPTH*XLEN-1:0] fwd_data;
    logic                      pipe_stall;
    logic                      flush;

    logic                      ex_valid;
    logic                      ex_rd_we;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         ex_rd;
    logic [XLEN-1:0]           ex_op_a;
    logic [XLEN-1:0]           ex_op_b;
    logic [XLEN-1:0]           ex_store_data;

    logic [31:0]               perf_stall_cnt;
    logic [31:0]               perf_fwd_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_rd, id_rd_we, id_is_load, id_use_imm, id_imm,
               fwd_data, pipe_stall, flush,
        input  id_ready, ex_valid, ex_rd_we, ex_is_load, ex_rd,
               ex_op_a, ex_op_b, ex_store_data, perf_stall_cnt, perf_fwd_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_rd, id_rd_we, id_is_load, id_use_imm, id_imm,
               fwd_data, pipe_stall, flush,
        output id_ready, ex_valid, ex_rd_we, ex_is_load, ex_rd,
               ex_op_a, ex_op_b, ex_store_data, perf_stall_cnt, perf_fwd_cnt
    );

endinterface

// File: rtl/opfwd_src_sel.sv
// Forwarding select for one source operand.
//   addr      : source register address
//   rf_data   : register-file read data for addr
//   sb        : in-flight scoreboard, entry 0 = EX (youngest)
//   fwd_data  : stage k result at [k*XLEN +: XLEN]
//   data      : resolved operand value
//   hit       : value came from a downstream stage
//   load_use  : youngest producer is a load still in EX (value not yet available)
module opfwd_src_sel
    import opfwd_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FWD_DEPTH = 3
) (
    input  logic [REG_AW-1:0]              addr,
    input  logic [XLEN-1:0]                rf_data,
    input  sb_entry_t [FWD_DEPTH-1:0]      sb,
    input  logic [FWD_DEPTH*XLEN-1:0]      fwd_data,
    output logic [XLEN-1:0]                data,
    output logic                           hit,
    output logic                           load_use
);

    opfwd_rd_t tag;

    assign tag = opfwd_rd_t'(addr);

    always_comb begin
        data     = rf_data;
        hit      = 1'b0;
        load_use = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites the others.
        for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
            if (sb_match(sb[k], tag)) begin
                data     = fwd_data[k*XLEN +: XLEN];
                hit      = 1'b1;
                load_use = sb[k].is_load & (k == 0);
            end
        end
        if (tag == OPFWD_ZERO_REG) begin
            data = '0;
        end
    end

endmodule

// File: rtl/opfwd_issue_stage.sv
// Registered ID->EX operand stage with an in-flight destination scoreboard,
// priority forwarding from FWD_DEPTH downstream stages, load-use interlock,
// freeze (pipe_stall) and flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : opfwd_issue_stage_if.slave (ID request, fwd_data, controls, EX register)
// Optional build macro OPFWD_PERF_EN adds saturating 32-bit stall / forward
// counters; without it perf_stall_cnt and perf_fwd_cnt read as 0.
module opfwd_issue_stage
    import opfwd_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FWD_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opfwd_issue_stage_if.slave   bus
);

    sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] store_q, store_d;

    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            hit_a, hit_b;
    logic            lu_a, lu_b;
    logic            load_use;
    logic            issue;

    opfwd_src_sel #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .FWD_DEPTH (FWD_DEPTH)
    ) u_src_a (
        .addr     (bus.id_rs1_addr),
        .rf_data  (bus.id_rs1_data),
        .sb       (sb_q),
        .fwd_data (bus.fwd_data),
        .data     (fwd_a),
        .hit      (hit_a),
        .load_use (lu_a)
    );

    opfwd_src_sel #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .FWD_DEPTH (FWD_DEPTH)
    ) u_src_b (
        .addr     (bus.id_rs2_addr),
        .rf_data  (bus.id_rs2_data),
        .sb       (sb_q),
        .fwd_data (bus.fwd_data),
        .data     (fwd_b),
        .hit      (hit_b),
        .load_use (lu_b)
    );

    // rs2 always feeds store data, so it is a used source even when operand B
    // takes the immediate.
    assign load_use     = lu_a | lu_b;
    assign bus.id_ready = ~bus.pipe_stall & ~load_use;
    assign issue        = bus.id_valid & bus.id_ready & ~bus.flush;

    always_comb begin
        sb_d    = sb_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        store_d = store_q;
        if (!bus.pipe_stall) begin
            for (int k = int'(FWD_DEPTH) - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            if (issue) begin
                sb_d[0].valid   = 1'b1;
                sb_d[0].rd      = opfwd_rd_t'(bus.id_rd);
                sb_d[0].we      = bus.id_rd_we;
                sb_d[0].is_load = bus.id_is_load;
                op_a_d          = fwd_a;
                op_b_d          = bus.id_use_imm ? bus.id_imm : fwd_b;
                store_d         = fwd_b;
            end else begin
                // Bubble: control cleared, operands and tag left as they were.
                sb_d[0].valid   = 1'b0;
                sb_d[0].we      = 1'b0;
                sb_d[0].is_load = 1'b0;
            end
        end else if (bus.flush) begin
            // Frozen pipe, but the instruction sitting in EX is still killed.
            sb_d[0].valid = 1'b0;
            sb_d[0].we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            store_q <= '0;
        end else begin
            sb_q    <= sb_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            store_q <= store_d;
        end
    end

    // Entry 0 is the EX register's control half.
    assign bus.ex_valid      = sb_q[0].valid;
    assign bus.ex_rd_we      = sb_q[0].we;
    assign bus.ex_is_load    = sb_q[0].is_load;
    assign bus.ex_rd         = sb_q[0].rd[REG_AW-1:0];
    assign bus.ex_op_a       = op_a_q;
    assign bus.ex_op_b       = op_b_q;
    assign bus.ex_store_data = store_q;

`ifdef OPFWD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (bus.id_valid && load_use && !bus.pipe_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (issue && (hit_a || hit_b) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_fwd_cnt   = fwd_cnt_q;
`else
    logic unused_hit;
    assign unused_hit         = hit_a ^ hit_b;
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_fwd_cnt   = '0;
`endif

endmodule
